// File: rtl/mem_lane_ctrl.sv
// Data-memory lane controller: steers stores onto byte lanes, extracts and extends loads,
// handshakes with a multi-cycle RAM and optionally splits accesses that straddle a lane word.
module mem_lane_ctrl #(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 32,
    parameter bit          ALLOW_UNALIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned SPAN_W = OFF_W + 1;
    localparam int unsigned BE2_W  = 2 * BYTES;
    localparam int unsigned WD2_W  = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    state_e             state_q;
    logic               we_q;
    logic               signed_q;
    logic               split_q;
    logic [1:0]         size_q;
    logic [OFF_W-1:0]   off_q;
    logic [BYTES-1:0]   be_hi_q;
    logic [DATA_W-1:0]  wd_hi_q;
    logic [DATA_W-1:0]  rd0_q;

    logic [OFF_W-1:0]   req_off;
    logic [3:0]         req_mask;
    logic [3:0]         req_n;
    logic               misaligned;
    logic               req_err;
    logic               req_split;
    logic [31:0]        wdata_m;
    logic [BE2_W-1:0]   be2;
    logic [WD2_W-1:0]   wd2;
    logic               last_ack;
    logic [WD2_W-1:0]   rd2;
    logic [31:0]        rd_raw;
    logic [31:0]        rd_ext;

    assign req_ready = (state_q == StIdle) && !reset;

    always_comb begin
        req_off = req_addr[OFF_W-1:0];
        unique case (req_size)
            2'd0: begin req_mask = 4'b1111; req_n = 4'd4; misaligned = |req_addr[1:0]; end
            2'd1: begin req_mask = 4'b0011; req_n = 4'd2; misaligned = req_addr[0];    end
            2'd2: begin req_mask = 4'b0001; req_n = 4'd1; misaligned = 1'b0;           end
            default: begin req_mask = 4'b0000; req_n = 4'd0; misaligned = 1'b0;        end
        endcase
        req_err   = (req_size == 2'd3) || (misaligned && !ALLOW_UNALIGNED);
        req_split = ({1'b0, req_off} + SPAN_W'(req_n)) > SPAN_W'(BYTES);

        // Bytes beyond the access width are dropped so idle lanes carry zero.
        for (int i = 0; i < 4; i++) begin
            wdata_m[8*i +: 8] = req_wdata[8*i +: 8] & {8{req_mask[i]}};
        end
        be2 = BE2_W'(req_mask) << req_off;
        wd2 = WD2_W'(wdata_m) << {req_off, 3'b000};

        last_ack = mem_ack && ((state_q == StBeat0 && !split_q) || state_q == StBeat1);
        rd2      = (state_q == StBeat1) ? {mem_rdata, rd0_q} : {{DATA_W{1'b0}}, mem_rdata};
        rd_raw   = 32'(rd2 >> {off_q, 3'b000});
        unique case (size_q)
            2'd1:    rd_ext = {{16{signed_q & rd_raw[15]}}, rd_raw[15:0]};
            2'd2:    rd_ext = {{24{signed_q & rd_raw[7]}}, rd_raw[7:0]};
            default: rd_ext = rd_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            split_q   <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            be_hi_q   <= '0;
            wd_hi_q   <= '0;
            rd0_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        off_q    <= req_off;
                        split_q  <= req_split;
                        be_hi_q  <= be2[BE2_W-1:BYTES];
                        wd_hi_q  <= wd2[WD2_W-1:DATA_W];
                        if (req_err) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state_q   <= StBeat0;
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_be    <= be2[BYTES-1:0];
                            mem_wdata <= wd2[DATA_W-1:0];
                        end
                    end
                end
                StBeat0: begin
                    // First half of a straddling access: keep mem_en up and move to the next word.
                    if (mem_ack && split_q) begin
                        state_q   <= StBeat1;
                        rd0_q     <= mem_rdata;
                        mem_addr  <= mem_addr + ADDR_W'(BYTES);
                        mem_be    <= be_hi_q;
                        mem_wdata <= wd_hi_q;
                    end
                end
                StResp:  state_q <= StIdle;
                default: ;
            endcase

            if (last_ack) begin
                state_q   <= StResp;
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
                mem_be    <= '0;
                mem_wdata <= '0;
                rsp_valid <= 1'b1;
                rsp_rdata <= we_q ? 32'd0 : rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Scoreboarded bench: byte-level reference model, randomized RAM latency, abort-on-reset
// scenario, plus directed checks on a 64-bit strict-alignment instance.
module tb_mem_lane_ctrl;

    localparam bit UNALIGNED_OK = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk  = 0;
    int errs = 0;

    // Main instance: 32-bit, unaligned accesses allowed.
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(UNALIGNED_OK)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Second instance: 64-bit, misaligned accesses rejected.
    logic        b_req_valid, b_req_ready, b_req_we, b_req_signed;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        b_mem_en, b_mem_we, b_mem_ack;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_be;
    logic [63:0] b_mem_wdata, b_mem_rdata;

    mem_lane_ctrl #(.DATA_W(64), .ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        bit          second;
        int          start_cyc;
    } beat_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          acc;
    } rsp_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    logic [7:0] ref_mem [logic [31:0]];
    logic [7:0] dev_mem [logic [31:0]];
    int  last_ack_cyc = 0;
    bit  hold_second  = 1'b0;
    bit  stray_ack    = 1'b0;

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : def_byte(a);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        chk++;
        errs++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: byte-by-byte view of the access; pushes expected beats and response.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n, guard, lane;
        bit          err;
        beat_t       b0, b1;
        rsp_t        r;
        logic [31:0] a, w0, val;
        guard = 0;
        @(negedge clk);
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                fail("req_ready timeout");
                return;
            end
        end
        n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 0;
        if (n == 0) err = 1'b1;
        else        err = !UNALIGNED_OK && (addr % n != 0);
        r.acc = cyc + 1;
        r.err = err;
        r.rdata = 32'd0;
        if (!err) begin
            w0 = addr & ~32'd3;
            b0.addr = w0;        b0.be = '0; b0.wdata = '0; b0.we = we;
            b0.second = 1'b0;    b0.start_cyc = r.acc;
            b1.addr = w0 + 32'd4; b1.be = '0; b1.wdata = '0; b1.we = we;
            b1.second = 1'b1;    b1.start_cyc = -1;
            val = '0;
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                lane = int'(a[1:0]);
                if ((a & ~32'd3) == w0) begin
                    b0.be[lane] = 1'b1;
                    b0.wdata[8*lane +: 8] = wdata[8*k +: 8];
                end else begin
                    b1.be[lane] = 1'b1;
                    b1.wdata[8*lane +: 8] = wdata[8*k +: 8];
                end
                if (we) ref_mem[a] = wdata[8*k +: 8];
                else    val[8*k +: 8] = ref_rd(a);
            end
            if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
            r.rdata = we ? 32'd0 : val;
            beat_q.push_back(b0);
            if (b1.be != 0) beat_q.push_back(b1);
        end
        rsp_q.push_back(r);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        // Scramble request fields: the controller must have registered them.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    // RAM responder with random wait states; checks each beat and that it is held while waiting.
    initial begin
        beat_t       cur;
        bit          active;
        int          wait_n;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        logic        s_we;
        active = 1'b0;
        wait_n = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (reset) begin
                active = 1'b0;
                continue;
            end
            if (!mem_en) begin
                mem_ack = stray_ack;
                continue;
            end
            if (!active) begin
                if (beat_q.size() == 0) begin
                    fail("unexpected mem_en beat");
                    mem_ack = 1'b1;
                    continue;
                end
                cur = beat_q.pop_front();
                active = 1'b1;
                wait_n = $urandom_range(0, 3);
                check("beat start cycle", cyc, cur.start_cyc >= 0 ? cur.start_cyc : last_ack_cyc);
                check("beat addr", mem_addr, cur.addr);
                check("beat be/we", {mem_be, mem_we}, {cur.be, cur.we});
                if (cur.we) check("beat wdata", mem_wdata, cur.wdata);
                s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wdata = mem_wdata;
            end else begin
                check("held addr", mem_addr, s_addr);
                check("held be/we/wdata", {mem_be, mem_we, mem_wdata}, {s_be, s_we, s_wdata});
            end
            if (hold_second && cur.second) continue;
            if (wait_n > 0) begin
                wait_n--;
                continue;
            end
            for (int l = 0; l < 4; l++) begin
                if (cur.we && mem_be[l]) dev_mem[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
                mem_rdata[8*l +: 8] = dev_rd(mem_addr + 32'(l));
            end
            mem_ack = 1'b1;
            last_ack_cyc = cyc + 1;
            active = 1'b0;
        end
    end

    // Response monitor.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail("unexpected rsp_valid");
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp err/rdata", {rsp_err, rsp_rdata}, {e.err, e.rdata});
                    check("rsp cycle", cyc, e.err ? e.acc : last_ack_cyc);
                end
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (rsp_q.size() != 0 || mem_en) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                fail("drain timeout");
                break;
            end
        end
        check("beats left", beat_q.size(), 0);
    endtask

    task automatic b_issue(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check("b ready", b_req_ready, 1'b1);
        b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_signed = sgn;
        b_req_addr = addr; b_req_wdata = wdata;
        @(negedge clk);
        b_req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_signed = 0; b_req_addr = 0;
        b_req_wdata = 0; b_mem_ack = 0; b_mem_rdata = 0;
        repeat (3) @(negedge clk);
        check("reset en/we/be", {mem_en, mem_we, mem_be}, 6'd0);
        check("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0);
        check("reset addr/wdata", {mem_addr, mem_wdata}, 64'd0);
        check("reset ready", req_ready, 1'b0);
        check("reset b mem_en", b_mem_en, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", req_ready, 1'b1);

        issue(1'b1, 2'd2, 1'b0, 32'h13, 32'hAB);
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001);
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h33221144);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  32'($urandom_range(0, 255)), $urandom);
        end
        drain();

        // Abort a split load while its second beat is stalled.
        hold_second = 1'b1;
        issue(1'b0, 2'd0, 1'b0, 32'h1F2, 32'h0);
        guard = 0;
        while (!(mem_en && mem_addr == 32'h1F4)) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                fail("second beat timeout");
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort mem_en", mem_en, 1'b0);
        check("abort rsp_valid", rsp_valid, 1'b0);
        check("ready in reset", req_ready, 1'b0);
        rsp_q.delete();
        beat_q.delete();
        hold_second = 1'b0;
        reset = 1'b0;
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ready after abort", req_ready, 1'b1);
            check("idle under stray ack", {mem_en, rsp_valid}, 2'b00);
        end
        stray_ack = 1'b0;
        issue(1'b0, 2'd2, 1'b1, 32'h1F3, 32'h0);
        drain();

        // 64-bit strict instance.
        b_issue(1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000BEEF);
        check("b sh addr", b_mem_addr, 32'h08);
        check("b sh en/we/be", {b_mem_en, b_mem_we, b_mem_be}, {2'b11, 8'hC0});
        check("b sh wdata", b_mem_wdata, 64'hBEEF_0000_0000_0000);
        b_mem_ack = 1'b1;
        @(negedge clk);
        b_mem_ack = 1'b0;
        check("b sh rsp", {b_rsp_valid, b_rsp_err, b_mem_en}, 3'b100);
        b_issue(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
        check("b lh be", b_mem_be, 8'hC0);
        b_mem_rdata = 64'h8001_1234_5678_9ABC;
        b_mem_ack = 1'b1;
        @(negedge clk);
        b_mem_ack = 1'b0;
        check("b lh rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {2'b10, 32'hFFFF8001});
        b_issue(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
        b_mem_ack = 1'b1;
        @(negedge clk);
        b_mem_ack = 1'b0;
        check("b lhu rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {2'b10, 32'h00008001});
        b_issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h1);
        check("b misaligned err", {b_rsp_valid, b_rsp_err, b_mem_en}, 3'b110);
        @(negedge clk);
        check("b err pulse", {b_rsp_valid, b_mem_en, b_req_ready}, 3'b001);

        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule
